// File: rtl/esm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : esm_pkg
//  Brief    : Shared defaults, instruction field ranges and index/count types
//             for the ESM instruction window.
//  Revision : 1.0 - initial release
// ============================================================================
package esm_pkg;

  localparam int ESM_INSTR_W = 32;
  localparam int ESM_BS      = 16;
  localparam int ESM_IDX_W   = $clog2(ESM_BS);

  // Register-specifier bit ranges inside a RISC-V style instruction word
  localparam int ESM_RD_MSB  = 11;
  localparam int ESM_RD_LSB  = 7;
  localparam int ESM_RS1_MSB = 19;
  localparam int ESM_RS1_LSB = 15;
  localparam int ESM_RS2_MSB = 24;
  localparam int ESM_RS2_LSB = 20;

  typedef logic [ESM_IDX_W-1:0] idx_t;
  typedef logic [ESM_IDX_W:0]   cnt_t;

endpackage
`default_nettype wire

// File: rtl/esm_ibuf_ptr.sv
`default_nettype none
// ============================================================================
//  Module   : esm_ibuf_ptr
//  Brief    : IDX_W-bit wrapping slot pointer with increment and clear.
//             Wrap from BS-1 to 0 is the natural modulo-2^IDX_W rollover.
//  Revision : 1.0 - initial release
// ============================================================================
module esm_ibuf_ptr #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [IDX_W-1:0] ptr
);

  logic [IDX_W-1:0] r_ptr;

  // Clear wins over increment so a flush always lands the pointer on slot 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (clr) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= r_ptr + IDX_W'(1);
    end
  end

  assign ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/esm_instr_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : esm_instr_buffer
//  Brief    : In-order BS-entry instruction window. Accepts decoded
//             instructions over valid/ready, assigns each a slot index and
//             forwards it (1-cycle latency) to dependency analysis. Retire
//             frees the oldest slot; flush empties the window.
//  Options  : ESM_IBUF_STATS_EN - adds stall_cycles[15:0], a saturating count
//             of cycles with in_valid && !in_ready (cleared by rst / flush).
//  Revision : 1.0 - initial release
// ============================================================================
module esm_instr_buffer
  import esm_pkg::*;
#(
  parameter int INSTR_W = ESM_INSTR_W,
  parameter int BS      = ESM_BS,
  parameter int IDX_W   = $clog2(BS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               in_regwrite,
  input  logic               in_alusrc,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic               out_regwrite,
  output logic               out_alusrc,
  output logic [IDX_W-1:0]   out_index,
  input  logic               retire,
  input  logic               flush,
  output logic [IDX_W:0]     count,
  output logic               full,
  output logic               empty
`ifdef ESM_IBUF_STATS_EN
  ,
  output logic [15:0]        stall_cycles
`endif
);

  localparam int             c_ent_w    = INSTR_W + 2;
  localparam logic [IDX_W:0] c_full_cnt = (IDX_W+1)'(BS);

  logic [IDX_W-1:0] w_head;
  logic [IDX_W-1:0] w_tail;
  logic [IDX_W:0]   r_count;
  logic             r_out_valid;
  logic [IDX_W-1:0] r_out_index;
  logic [c_ent_w-1:0] r_mem [BS];
  logic [c_ent_w-1:0] w_out_entry;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_retire;

  // Status comes only from the registered count, so in_ready never sees retire
  assign w_full   = (r_count == c_full_cnt);
  assign w_empty  = (r_count == '0);
  assign in_ready = !w_full && !flush;
  assign w_accept = in_valid && in_ready;
  assign w_retire = retire && !w_empty && !flush;

  esm_ibuf_ptr #(.IDX_W(IDX_W)) u_head_ptr (
    .clk (clk),
    .rst (rst),
    .inc (w_retire),
    .clr (flush),
    .ptr (w_head)
  );

  esm_ibuf_ptr #(.IDX_W(IDX_W)) u_tail_ptr (
    .clk (clk),
    .rst (rst),
    .inc (w_accept),
    .clr (flush),
    .ptr (w_tail)
  );

  // Occupancy tracked from accept/retire deltas; simultaneous pair cancels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_accept && !w_retire) begin
      r_count <= r_count + (IDX_W+1)'(1);
    end else if (!w_accept && w_retire) begin
      r_count <= r_count - (IDX_W+1)'(1);
    end
  end

  // Allocation pulse and slot index of the entry just written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_index <= '0;
    end else begin
      r_out_valid <= w_accept;
      if (w_accept) begin
        r_out_index <= w_tail;
      end
    end
  end

  // Window storage; the forwarded data is read back from the newest slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_accept) begin
      r_mem[w_tail] <= {in_instr, in_regwrite, in_alusrc};
    end
  end

  // Every write also moves r_out_index onto that slot, so this read is always
  // the last accepted entry and holds its value while out_valid is low.
  assign w_out_entry  = r_mem[r_out_index];
  assign out_instr    = w_out_entry[c_ent_w-1:2];
  assign out_regwrite = w_out_entry[1];
  assign out_alusrc   = w_out_entry[0];
  assign out_valid    = r_out_valid;
  assign out_index    = r_out_index;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;

  // Head pointer marks the oldest entry for retire-side consumers of r_mem
  logic w_unused_head;
  assign w_unused_head = ^w_head;

`ifdef ESM_IBUF_STATS_EN
  logic [15:0] r_stall_cycles;

  // Saturating count of upstream stall cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (flush) begin
      r_stall_cycles <= '0;
    end else if (in_valid && !in_ready && (r_stall_cycles != 16'hFFFF)) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire
